// File: rtl/modn_updown_counter_pkg.sv
// Shared constants and helpers for the mod-N up/down counter.
// Holds default sizing, legal ranges and the digit width function.
package modn_updown_counter_pkg;

  localparam int RADIX_DEF  = 10;
  localparam int DIGITS_DEF = 4;
  localparam int RADIX_MIN  = 2;
  localparam int RADIX_MAX  = 16;
  localparam int DIGITS_MIN = 1;
  localparam int DIGITS_MAX = 8;

  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  function automatic bit cfg_ok(input int r, input int d);
    return (r >= RADIX_MIN) && (r <= RADIX_MAX) &&
           (d >= DIGITS_MIN) && (d <= DIGITS_MAX);
  endfunction

endpackage

// File: rtl/modn_updown_counter_if.sv
// Control/status bundle between a counter user and the counter.
// The master drives controls; the slave (counter) returns count and flags.
interface modn_updown_counter_if #(
  parameter int W = 16
);

  logic         en;
  logic         up_down;
  logic         load;
  logic [W-1:0] load_val;
  logic         clr_ovf;
  logic [W-1:0] out;
  logic         tc;
  logic         ovf;

  modport master (
    output en, up_down, load, load_val, clr_ovf,
    input  out, tc, ovf
  );

  modport slave (
    input  en, up_down, load, load_val, clr_ovf,
    output out, tc, ovf
  );

endinterface

// File: rtl/modn_updown_counter_digit.sv
// One mod-RADIX digit: saturating load, wrap on step, edge flags.
// Load beats step; reset beats both.
module modn_digit
  import modn_updown_counter_pkg::*;
#(
  parameter  int RADIX = RADIX_DEF,
  localparam int DW    = clog2(RADIX)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step_i,
  input  logic          up_i,
  input  logic          load_i,
  input  logic [DW-1:0] load_val_i,
  output logic [DW-1:0] value_o,
  output logic          at_max_o,
  output logic          at_zero_o
);

  localparam logic [DW-1:0] MAXV = DW'(RADIX - 1);

  logic [DW-1:0] val_q;
  logic [DW-1:0] val_d;
  logic [DW-1:0] sat_val;

  assign sat_val   = (load_val_i > MAXV) ? MAXV : load_val_i;
  assign at_max_o  = (val_q == MAXV);
  assign at_zero_o = (val_q == '0);
  assign value_o   = val_q;

  always_comb begin
    val_d = val_q;
    unique case (1'b1)
      load_i:
        val_d = sat_val;
      !load_i && step_i && up_i:
        val_d = at_max_o ? '0 : val_q + 1'b1;
      !load_i && step_i && !up_i:
        val_d = at_zero_o ? MAXV : val_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) val_q <= '0;
    else     val_q <= val_d;
  end

endmodule

// File: rtl/modn_updown_counter.sv
// Cascaded mod-RADIX up/down counter with ripple tc and sticky wrap flag.
// Each digit steps when every lower digit sits at its wrap value.
module modn_updown_counter
  import modn_updown_counter_pkg::*;
#(
  parameter  int RADIX  = RADIX_DEF,
  parameter  int DIGITS = DIGITS_DEF,
  localparam int DW     = clog2(RADIX)
) (
  input  logic                  clk,
  input  logic                  rst,
  modn_updown_counter_if.slave  bus
);

  if (!cfg_ok(RADIX, DIGITS)) begin : g_bad_cfg
    $error("modn_updown_counter: RADIX/DIGITS out of range");
  end

  logic [DIGITS-1:0]    step;
  logic [DIGITS-1:0]    carry;
  logic [DIGITS-1:0]    at_max;
  logic [DIGITS-1:0]    at_zero;
  logic [DIGITS*DW-1:0] out_w;
  logic                 tc_w;
  logic                 ovf_q;
  logic                 ovf_d;

  assign step[0] = bus.en & ~bus.load;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    modn_digit #(
      .RADIX (RADIX)
    ) u_dig (
      .clk        (clk),
      .rst        (rst),
      .step_i     (step[g]),
      .up_i       (bus.up_down),
      .load_i     (bus.load),
      .load_val_i (bus.load_val[g*DW +: DW]),
      .value_o    (out_w[g*DW +: DW]),
      .at_max_o   (at_max[g]),
      .at_zero_o  (at_zero[g])
    );

    assign carry[g] = step[g] &
      (bus.up_down ? at_max[g] : at_zero[g]);

    if (g > 0) begin : g_chain
      assign step[g] = carry[g-1];
    end
  end

  // Carry out of the top digit is exactly a full-range wrap.
  assign tc_w = carry[DIGITS-1];

  always_comb begin
    ovf_d = ovf_q;
    if (tc_w)             ovf_d = 1'b1;
    else if (bus.clr_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign bus.out = out_w;
  assign bus.tc  = tc_w;
  assign bus.ovf = ovf_q;

endmodule

// File: tb/tb_modn_updown_counter.sv
// Scoreboard bench for three counter configurations sharing one clock.
// Expected count is kept as a plain integer modulo RADIX**DIGITS.
module tb_modn_updown_counter;

  typedef struct {
    int         k;
    logic       tc;
    logic [7:0] out;
    logic       ovf;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0 = 1'b1;
  logic rst1 = 1'b1;
  logic rst2 = 1'b1;

  modn_updown_counter_if #(.W(8)) if0 ();
  modn_updown_counter_if #(.W(4)) if1 ();
  modn_updown_counter_if #(.W(8)) if2 ();

  modn_updown_counter #(.RADIX(10), .DIGITS(2)) u0 (
    .clk (clk), .rst (rst0), .bus (if0.slave)
  );
  modn_updown_counter #(.RADIX(16), .DIGITS(1)) u1 (
    .clk (clk), .rst (rst1), .bus (if1.slave)
  );
  modn_updown_counter #(.RADIX(2), .DIGITS(8)) u2 (
    .clk (clk), .rst (rst2), .bus (if2.slave)
  );

  int R [3] = '{10, 16, 2};
  int D [3] = '{2, 1, 8};
  int W [3] = '{4, 4, 1};

  int   cnt [3];
  bit   om  [3];
  exp_t q [$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   stim_done = 1'b0;

  function automatic int pw(input int b, input int e);
    int r;
    r = 1;
    for (int i = 0; i < e; i++) r = r * b;
    return r;
  endfunction

  function automatic int decode(input int k, input logic [7:0] lv);
    int v;
    int d;
    logic [7:0] t;
    v = 0;
    for (int i = 0; i < D[k]; i++) begin
      t = lv >> (i * W[k]);
      d = int'(t) & ((1 << W[k]) - 1);
      if (d >= R[k]) d = R[k] - 1;
      v = v + d * pw(R[k], i);
    end
    return v;
  endfunction

  function automatic logic [7:0] encode(input int k, input int v);
    logic [7:0] p;
    int d;
    p = '0;
    for (int i = 0; i < D[k]; i++) begin
      d = (v / pw(R[k], i)) % R[k];
      p = p | 8'(d << (i * W[k]));
    end
    return p;
  endfunction

  task automatic drv(input int k, input bit r, input bit l,
                     input logic [7:0] lv, input bit e,
                     input bit ud, input bit c);
    exp_t x;
    int n;
    @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    if0.en = 1'b0; if0.load = 1'b0; if0.clr_ovf = 1'b0;
    if1.en = 1'b0; if1.load = 1'b0; if1.clr_ovf = 1'b0;
    if2.en = 1'b0; if2.load = 1'b0; if2.clr_ovf = 1'b0;
    case (k)
      0: begin
        rst0 = r; if0.load = l; if0.load_val = lv;
        if0.en = e; if0.up_down = ud; if0.clr_ovf = c;
      end
      1: begin
        rst1 = r; if1.load = l; if1.load_val = lv[3:0];
        if1.en = e; if1.up_down = ud; if1.clr_ovf = c;
      end
      default: begin
        rst2 = r; if2.load = l; if2.load_val = lv;
        if2.en = e; if2.up_down = ud; if2.clr_ovf = c;
      end
    endcase
    n = pw(R[k], D[k]);
    x.k  = k;
    x.tc = e && !l && (ud ? (cnt[k] == n - 1) : (cnt[k] == 0));
    if (r) begin
      cnt[k] = 0;
      om[k]  = 1'b0;
    end else begin
      if (l)      cnt[k] = decode(k, lv);
      else if (e) cnt[k] = ud ? (cnt[k] + 1) % n : (cnt[k] + n - 1) % n;
      if (x.tc)   om[k] = 1'b1;
      else if (c) om[k] = 1'b0;
    end
    x.out = encode(k, cnt[k]);
    x.ovf = om[k];
    q.push_back(x);
  endtask

  task automatic rnd(input int k, input int n);
    for (int i = 0; i < n; i++)
      drv(k, $urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0,
          8'($urandom), $urandom_range(0, 3) != 0,
          $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0);
  endtask

  task automatic sweep(input int k);
    int n;
    n = pw(R[k], D[k]);
    drv(k, 1, 0, 8'h00, 0, 1, 0);
    repeat (2 * n + 1) drv(k, 0, 0, 8'h00, 1, 1, 0);
    drv(k, 0, 0, 8'h00, 0, 1, 1);
    repeat (2 * n + 1) drv(k, 0, 0, 8'h00, 1, 0, 0);
  endtask

  task automatic check(input string nm, input int k,
                       input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cfg%0d t=%0t: got %h want %h",
               nm, k, $time, act, exp);
    end
  endtask

  initial begin
    if0.en = 0; if0.up_down = 1; if0.load = 0; if0.load_val = '0; if0.clr_ovf = 0;
    if1.en = 0; if1.up_down = 1; if1.load = 0; if1.load_val = '0; if1.clr_ovf = 0;
    if2.en = 0; if2.up_down = 1; if2.load = 0; if2.load_val = '0; if2.clr_ovf = 0;

    drv(0, 1, 0, 8'h00, 0, 1, 0);
    repeat (5) drv(0, 0, 0, 8'h00, 0, 1, 0);
    drv(0, 0, 1, 8'h98, 0, 1, 0);
    repeat (3) drv(0, 0, 0, 8'h00, 1, 1, 0);
    drv(0, 0, 0, 8'h00, 0, 1, 1);
    drv(0, 0, 1, 8'h00, 0, 0, 0);
    repeat (2) drv(0, 0, 0, 8'h00, 1, 0, 0);
    drv(0, 0, 1, 8'h90, 0, 0, 0);
    drv(0, 0, 0, 8'h00, 1, 0, 0);
    drv(0, 0, 1, 8'h5F, 0, 1, 0);
    drv(0, 0, 1, 8'h99, 1, 1, 0);
    drv(0, 0, 1, 8'h47, 0, 1, 0);
    drv(0, 0, 0, 8'h00, 1, 1, 0);
    drv(0, 1, 1, 8'h55, 1, 1, 0);
    drv(0, 0, 0, 8'h00, 1, 1, 0);
    drv(0, 0, 1, 8'h99, 0, 1, 1);
    drv(0, 0, 0, 8'h00, 1, 1, 1);
    rnd(0, 300);

    sweep(1);
    rnd(1, 200);
    sweep(2);
    rnd(2, 200);
    stim_done = 1'b1;
  end

  initial begin
    exp_t e;
    int cyc;
    logic [7:0] a_out;
    logic a_tc;
    logic a_ovf;
    cyc = 0;
    while (1) begin
      @(negedge clk);
      #2;
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        case (e.k)
          0:       a_tc = if0.tc;
          1:       a_tc = if1.tc;
          default: a_tc = if2.tc;
        endcase
        check("tc", e.k, {7'd0, a_tc}, {7'd0, e.tc});
        @(posedge clk);
        #1;
        case (e.k)
          0:       begin a_out = if0.out;          a_ovf = if0.ovf; end
          1:       begin a_out = {4'd0, if1.out};  a_ovf = if1.ovf; end
          default: begin a_out = if2.out;          a_ovf = if2.ovf; end
        endcase
        check("out", e.k, a_out, e.out);
        check("ovf", e.k, {7'd0, a_ovf}, {7'd0, e.ovf});
      end else if (stim_done) begin
        break;
      end
      if (cyc > 60000) begin
        n_bad++;
        $display("FAIL timeout: got %0d cycles want <= 60000", cyc);
        break;
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
